adapter_rx_crd_buf: RTL
=======================

Name: adapter_rx_crd_buf

Overview:
- Receive-side flit buffer that sits directly downstream of the link egress of adapter_core.
- Accepts command/data flits from the link and holds them in a credit-sized FIFO.
- Presents flits to the protocol layer with a valid/ready handshake.
- Returns one credit pulse per freed entry; this pulse drives tx_crd_i of the peer adapter_core, whose initial credit count must equal DEPTH.

Parameters:
- DATA_W, 64: flit width in bits.
- DEPTH, 16: FIFO entries, which is also the credit count granted to the sender. Must be ≥2.
- CNT_W, $clog2(DEPTH+1): width of the level and pending-credit counters.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- enable, input, 1: block enable; 1 = RUN, 0 = drain then idle.
- link_vld_i, input, 1: a flit is present on the link this cycle (no backpressure).
- link_data_i, input, DATA_W: flit payload.
- out_vld_o, output, 1: head flit valid toward the protocol layer.
- out_data_o, output, DATA_W: head flit payload.
- out_rdy_i, input, 1: protocol layer accepts the head flit.
- crd_ret_o, output, 1: one-cycle pulse; each pulse returns one credit.
- level_o, output, CNT_W: number of occupied entries.
- fifo_empty_o, output, 1: level_o == 0.
- fifo_full_o, output, 1: level_o == DEPTH.
- ovf_err_o, output, 1: sticky; a flit arrived while the FIFO was full.
- state_o, output, 2: current FSM state.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE; pointers, level, pending credit and ovf_err_o = 0.
  - out_vld_o = 0, crd_ret_o = 0, fifo_empty_o = 1, fifo_full_o = 0.
  - Reset mid-operation discards all stored flits and all pending credits, without returning them.
- FSM states are IDLE = 0, RUN = 1, DRAIN = 2.
  - IDLE -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0.
  - DRAIN -> RUN when enable = 1.
  - DRAIN -> IDLE when the FIFO is empty and pending credit = 0.
- Write:
  - A flit is stored when state == RUN and link_vld_i = 1 and not full.
  - In IDLE or DRAIN, link flits are ignored, with no error.
  - In RUN, a write while full drops the flit and sets ovf_err_o, which stays set until reset.
- Read and output timing:
  - out_vld_o = ~empty and (state != IDLE).
  - out_data_o = mem[rd_ptr], combinational show-ahead.
  - A pop occurs when out_vld_o & out_rdy_i.
  - Write-to-out_vld_o latency is 1 cycle.
- Push and pop in the same cycle:
  - Level is unchanged.
  - This is legal when full: the pop frees the entry, the push is accepted and there is no overflow.
- Pointer arithmetic:
  - Pointers run 0..DEPTH-1 and wrap to 0 explicitly; DEPTH need not be a power of 2.
  - level_o is an up/down counter.
- Credit return:
  - pend_crd (CNT_W) increments on every pop.
  - crd_ret_o is registered. If pend_crd > 0 it asserts for one cycle and pend_crd decrements.
  - A pop in the same cycle as a return leaves pend_crd unchanged.
  - Maximum rate is 1 credit per cycle. Earliest crd_ret_o is the cycle after the pop.
  - Invariant: level + pend_crd + credits held by the sender == DEPTH.
- level_o, fifo_empty_o and fifo_full_o are registered and consistent with the post-edge state.

Optional Feature:
ADAPTER_RX_BYPASS_EN
- Defined: in RUN, when the FIFO is empty, link_vld_i = 1 and out_rdy_i = 1, the flit is not stored.
  - out_vld_o = 1 and out_data_o = link_data_i in the same cycle (zero latency).
  - The bypass counts as a pop, so pend_crd increments.
  - If out_rdy_i = 0 in that case, the flit is stored normally.
- Undefined: no combinational path from link to output; minimum latency is 1 cycle.

Decomposition:
- adapter_pkg holds:
  - the rx_state_e enum (IDLE/RUN/DRAIN);
  - the default ADAPTER_DATA_W;
  - the credit/depth constant ADAPTER_RX_DEPTH, shared with adapter_core's credit init.
- Sub-module adapter_sync_fifo (parameters DATA_W, DEPTH) provides storage, pointers, level, full and empty.
- The FSM, credit return and error flag stay in the top level.

Test Plan:
- Single flit: link_vld_i = 1 with data 0xA5 in RUN, out_rdy_i = 1 -> out_vld_o high one cycle later with 0xA5; crd_ret_o pulses exactly once, one cycle after the pop; level returns to 0.
- Fill: 16 back-to-back flits with out_rdy_i = 0 -> fifo_full_o = 1 and level_o = 16. A 17th flit -> ovf_err_o = 1 and level stays 16. Drain all 16 -> 16 crd_ret_o pulses, data in order.
- Full push/pop: at level 16, link_vld_i = 1 and a pop in the same cycle -> level stays 16 and ovf_err_o stays 0.
- Pop burst: 5 consecutive pops -> crd_ret_o high for exactly 5 consecutive cycles, starting one cycle after the first pop.
- Drain: level 3, enable -> 0 -> state DRAIN and link flits ignored. After 3 pops and 3 returns -> IDLE, state_o = 0.
- Mid-run reset: rst_n = 0 at level 7 with pend_crd 2 -> next cycle level 0, crd_ret_o = 0, state IDLE, ovf_err_o cleared.

Source files
------------

// File: rtl/adapter_rx_crd_buf_pkg.sv
// Shared adapter constants and the receive-buffer FSM encoding.
package adapter_pkg;

  localparam int unsigned ADAPTER_DATA_W   = 64;
  // Must match the initial credit count loaded by adapter_core.
  localparam int unsigned ADAPTER_RX_DEPTH = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } rx_state_e;

endpackage

// File: rtl/adapter_rx_crd_buf_if.sv
// Link-side flit input and protocol-side valid/ready output of the receive buffer.
interface adapter_rx_crd_buf_if
  import adapter_pkg::*;
#(
  parameter int unsigned DATA_W = ADAPTER_DATA_W
) ();

  logic              link_vld_i;
  logic [DATA_W-1:0] link_data_i;
  logic              out_vld_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_rdy_i;

  modport master (
    output link_vld_i,
    output link_data_i,
    output out_rdy_i,
    input  out_vld_o,
    input  out_data_o
  );

  modport slave (
    input  link_vld_i,
    input  link_data_i,
    input  out_rdy_i,
    output out_vld_o,
    output out_data_o
  );

endinterface

// File: rtl/adapter_sync_fifo.sv
// Synchronous show-ahead FIFO with explicit pointer wrap and registered level/full/empty.
module adapter_sync_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  level,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic              empty_q, full_q;

  // DEPTH need not be a power of two, so wrap on the last index rather than on overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    level_d = level_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign level = level_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/adapter_rx_crd_buf.sv
// Credit-based receive flit buffer feeding the protocol layer; each freed entry returns one credit.
// Optional zero-latency empty-FIFO bypass is enabled by defining ADAPTER_RX_BYPASS_EN.
module adapter_rx_crd_buf
  import adapter_pkg::*;
#(
  parameter int unsigned DATA_W = ADAPTER_DATA_W,
  parameter int unsigned DEPTH  = ADAPTER_RX_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  adapter_rx_crd_buf_if.slave        bus,
  output logic                       crd_ret_o,
  output logic [CNT_W-1:0]           level_o,
  output logic                       fifo_empty_o,
  output logic                       fifo_full_o,
  output logic                       ovf_err_o,
  output logic [1:0]                 state_o
);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              crd_ret_q, crd_ret_d;
  logic              ovf_q;

  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_vld, fifo_pop, fifo_push;
  logic              link_run, bypass, pop_any;

  assign link_run = (state_q == StRun) & bus.link_vld_i;
  assign fifo_vld = ~fifo_empty & (state_q != StIdle);
  assign fifo_pop = fifo_vld & bus.out_rdy_i;

`ifdef ADAPTER_RX_BYPASS_EN
  // An empty FIFO with a ready consumer hands the link flit straight through.
  assign bypass         = link_run & fifo_empty & bus.out_rdy_i;
  assign bus.out_vld_o  = fifo_vld | bypass;
  assign bus.out_data_o = bypass ? bus.link_data_i : fifo_rdata;
`else
  assign bypass         = 1'b0;
  assign bus.out_vld_o  = fifo_vld;
  assign bus.out_data_o = fifo_rdata;
`endif

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign fifo_push = link_run & ~bypass & (~fifo_full | fifo_pop);
  assign pop_any   = fifo_pop | bypass;

  adapter_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.link_data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (level_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A fresh pop is returned on the next cycle; older owed credits drain at one per cycle.
  always_comb begin
    crd_ret_d = pop_any | (pend_q != '0);
    pend_d    = pend_q + CNT_W'(pop_any) - CNT_W'(crd_ret_d);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (fifo_empty && (pend_q == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      crd_ret_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      crd_ret_q <= crd_ret_d;
      if (link_run && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign crd_ret_o    = crd_ret_q;
  assign fifo_empty_o = fifo_empty;
  assign fifo_full_o  = fifo_full;
  assign ovf_err_o    = ovf_q;
  assign state_o      = state_q;

endmodule
